// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing (1 start, DATA_WIDTH data LSB-first, 1 stop, idle high).
// Two-flop line synchronizer, start-bit validation at mid-bit, one-cycle valid/frame_error pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 38400,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_error_q, frame_error_d;
  logic [1:0]            sync_q;
  logic                  line_s;

  // Sync flops reset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line};
    end
  end

  assign line_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!line_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          if (!line_s) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          // LSB-first: new bit enters at the top and walks down to bit 0.
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = line_s;
          cnt_d                   = '0;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (line_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitIdle: begin
        if (line_s) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of uart_tx. It uses the same framing: 1 start bit (low), DATA_WIDTH data bits LSB-first, 1 stop bit (high), no parity, idle high.
The block synchronizes the asynchronous serial line, detects and validates the start bit, and samples each bit at mid-bit.
It presents each received word with a one-cycle valid pulse and flags stop-bit violations.
It is used on the receive path and in the uart_tx loopback bench.

Parameters:
CLK_FREQ, 38400, clock frequency in Hz
BAUDRATE, 9600, line bit rate in baud
DATA_WIDTH, 8, data bits per frame
Derived localparams (not overridable):
- CLKS_PER_BIT = CLK_FREQ / BAUDRATE, integer division; required >= 4.
- HALF_BIT = CLKS_PER_BIT / 2.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
line  input  1  asynchronous serial input, idle high
data  output  DATA_WIDTH  last correctly received word
valid  output  1  one-cycle pulse, data updated this cycle
frame_error  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, counters cleared, shift register cleared.
  - data=0, valid=0, frame_error=0, busy=0.
  - Both synchronizer flops are set to 1.
  - Reset takes effect mid-frame and discards any partial frame.
- Synchronizer: line passes through 2 flops to give line_s; line_s is the only internal view of the line.
- Bit counter cnt spans 0..CLKS_PER_BIT-1. Bit index spans 0..DATA_WIDTH-1.
- States:
  - IDLE: when line_s==0, go to START with cnt=0.
  - START: cnt increments each edge. At the edge where cnt==HALF_BIT-1:
    - line_s==0: go to DATA, cnt=0, idx=0.
    - line_s==1 (glitch): go to IDLE; no output pulse.
  - DATA: at the edge where cnt==CLKS_PER_BIT-1:
    - shift line_s in (LSB-first, so the first bit lands at data[0]); cnt=0; idx++.
    - after the DATA_WIDTH-th sample, go to STOP.
  - STOP: at the edge where cnt==CLKS_PER_BIT-1:
    - line_s==1: data<=shift register, valid=1 for one cycle, go to IDLE.
    - line_s==0: frame_error=1 for one cycle, data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until line_s==1, then go to IDLE. This prevents a stuck-low line or a break from retriggering.
- Timing: let t0 be the first clk edge that samples line low.
  - Start is checked at edge t0+2+HALF_BIT.
  - Data bit i is sampled at edge t0+2+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - Stop is sampled at edge t0+2+HALF_BIT+(DATA_WIDTH+1)*CLKS_PER_BIT; valid/frame_error rise on that edge.
  - With the defaults this is t0+40.
- Back-to-back frames: the block returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected. No minimum gap is required.
- valid and frame_error are never high in the same cycle and are never high for more than one cycle.
- data holds its value until the next valid frame.
- No flow control: a new frame overwrites data regardless of whether the consumer has read the previous word.

Test Plan:
- Defaults; drive 0xA5 frame (line: 0,1,0,1,0,0,1,0,1,1) at 4 clk/bit from t0 -> valid=1 only at t0+40 with data=0xA5; frame_error stays 0; busy high from t0+2 to t0+40.
- Frames 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses 40 clk apart; data=0x00 then 0xFF.
- Line low for 1 clk then high (glitch) -> no valid/frame_error; busy returns to 0 within HALF_BIT+3 clk; a subsequent 0x5A frame is received correctly.
- Receive 0x11 first, then a 0x3C frame with stop bit driven 0 and line held low for 20 clk more -> frame_error pulse at the stop sample, no valid, data stays 0x11; no new frame starts until line returns high; next 0xC3 frame is received correctly.
- Assert rst_n=0 for 1 clk at mid-bit 4 of a frame, then send 0x7E -> outputs 0 after reset; the aborted frame produces no pulse (line held high after reset until the new frame); 0x7E is received correctly.
- Loopback with uart_tx (same parameters) sending a 32-byte ROM sequence -> all 32 bytes match in order; frame_error never asserted.
